// File: rtl/iq_frame_serializer_pkg.sv
// Shared types and helpers for the IQ frame serializer.
// Optional sync header is enabled with IQ_SER_SYNC_HEADER_EN.
package iq_ser_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    HDR0 = 3'd3,
    HDR1 = 3'd4
  } ser_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef IQ_SER_SYNC_HEADER_EN
  localparam int HDR_LEN = 2;
`else
  localparam int HDR_LEN = 0;
`endif

  function automatic int data_len(input int num_ch, input int bytes_per_comp);
    return num_ch * 2 * bytes_per_comp;
  endfunction

  function automatic int frame_len(input int num_ch, input int bytes_per_comp);
    return data_len(num_ch, bytes_per_comp) + HDR_LEN;
  endfunction

endpackage

// File: rtl/iq_frame_serializer_if.sv
// Byte-stream valid/ready link from the serializer toward the USB/FIFO bridge.
interface iq_frame_serializer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_first;
  logic       out_last;

  modport master (output out_data, out_valid, out_first, out_last, input out_ready);
  modport slave  (input out_data, out_valid, out_first, out_last, output out_ready);
endinterface

// File: rtl/iq_sample_fifo.sv
// Two-deep FIFO of complete sample sets; flush has priority and may be paired with a push.
module iq_sample_fifo #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   level,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_pop;
  logic         do_push;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when an entry leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (flush) begin
      if (push) begin
        mem[1'b0] <= wdata;
      end else begin
        mem[1'b0] <= mem[1'b0];
      end
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end else begin
      mem[wr_ptr] <= mem[wr_ptr];
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= push;
      rd_ptr <= 1'b0;
      count  <= {1'b0, push};
    end else begin
      wr_ptr <= do_push ? ~wr_ptr : wr_ptr;
      rd_ptr <= do_pop ? ~rd_ptr : rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/iq_frame_serializer.sv
// Captures NUM_CH complex samples per strobe and streams them as byte frames.
// Define IQ_SER_SYNC_HEADER_EN to prefix each frame with 8'hA5 and a sequence byte.
module iq_frame_serializer
  import iq_ser_pkg::*;
#(
  parameter int SAMPLE_W       = 24,
  parameter int BYTES_PER_COMP = 2,
  parameter int NUM_CH         = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       capture,
  input  logic                       start,
  input  logic [NUM_CH*SAMPLE_W-1:0] inp_re,
  input  logic [NUM_CH*SAMPLE_W-1:0] inp_im,
  iq_frame_serializer_if.master      bus,
  output logic                       ovf,
  output logic [1:0]                 buf_level
);

  localparam int F     = data_len(NUM_CH, BYTES_PER_COMP);
  localparam int IDX_W = $clog2(F);
  localparam int SET_W = 2 * NUM_CH * SAMPLE_W;
  localparam int LSB0  = SAMPLE_W - 8 * BYTES_PER_COMP;

  ser_state_e       state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [7:0]       cur_data, data_nx;
  logic             cur_valid, valid_nx;
  logic             cur_first, first_nx;
  logic             cur_last, last_nx;
  logic             pop, load, hs, last_idx;
  logic             fifo_full, fifo_empty;
  logic [SET_W-1:0] fifo_rdata, work;
  logic [7:0]       work_bytes [F];
`ifdef IQ_SER_SYNC_HEADER_EN
  logic [7:0]       seq, seq_nx;
`endif

  iq_sample_fifo #(.W(SET_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start),
    .push  (capture),
    .pop   (pop),
    .wdata ({inp_im, inp_re}),
    .rdata (fifo_rdata),
    .level (buf_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Byte k of a frame: channel-major, re before im, low byte of the kept MSBs first.
  for (genvar k = 0; k < F; k++) begin : g_byte
    localparam int CH   = k / (2 * BYTES_PER_COMP);
    localparam int COMP = (k % (2 * BYTES_PER_COMP)) / BYTES_PER_COMP;
    localparam int B    = k % BYTES_PER_COMP;
    localparam int OFF  = COMP * NUM_CH * SAMPLE_W + CH * SAMPLE_W + LSB0 + 8 * B;
    assign work_bytes[k] = work[OFF +: 8];
  end

  assign hs       = cur_valid & bus.out_ready;
  assign last_idx = (idx == IDX_W'(F - 1));

  assign bus.out_data  = cur_data;
  assign bus.out_valid = cur_valid;
  assign bus.out_first = cur_first;
  assign bus.out_last  = cur_last;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    data_nx  = cur_data;
    valid_nx = cur_valid;
    first_nx = cur_first;
    last_nx  = cur_last;
    pop      = 1'b0;
    load     = 1'b0;
`ifdef IQ_SER_SYNC_HEADER_EN
    seq_nx   = seq;
`endif
    if (start) begin
      state_nx = IDLE;
      idx_nx   = {IDX_W{1'b0}};
      data_nx  = 8'h00;
      valid_nx = 1'b0;
      first_nx = 1'b0;
      last_nx  = 1'b0;
`ifdef IQ_SER_SYNC_HEADER_EN
      seq_nx   = 8'h00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            load     = 1'b1;
            state_nx = LOAD;
          end else begin
            state_nx = IDLE;
          end
        end
        LOAD: begin
          valid_nx = 1'b1;
          first_nx = 1'b1;
          last_nx  = 1'b0;
          idx_nx   = {IDX_W{1'b0}};
`ifdef IQ_SER_SYNC_HEADER_EN
          data_nx  = SYNC_BYTE;
          state_nx = HDR0;
`else
          data_nx  = work_bytes[0];
          state_nx = SEND;
`endif
        end
`ifdef IQ_SER_SYNC_HEADER_EN
        HDR0: begin
          if (hs) begin
            data_nx  = seq;
            first_nx = 1'b0;
            state_nx = HDR1;
          end else begin
            state_nx = HDR0;
          end
        end
        HDR1: begin
          if (hs) begin
            data_nx  = work_bytes[0];
            seq_nx   = seq + 8'd1;
            state_nx = SEND;
          end else begin
            state_nx = HDR1;
          end
        end
`endif
        SEND: begin
          if (hs && last_idx) begin
            // Back-to-back frames: pop and present the next frame's lead byte without a gap.
            if (!fifo_empty) begin
              pop      = 1'b1;
              load     = 1'b1;
              idx_nx   = {IDX_W{1'b0}};
              first_nx = 1'b1;
              last_nx  = 1'b0;
`ifdef IQ_SER_SYNC_HEADER_EN
              data_nx  = SYNC_BYTE;
              state_nx = HDR0;
`else
              data_nx  = fifo_rdata[LSB0 +: 8];
              state_nx = SEND;
`endif
            end else begin
              valid_nx = 1'b0;
              first_nx = 1'b0;
              last_nx  = 1'b0;
              state_nx = IDLE;
            end
          end else if (hs) begin
            idx_nx   = idx + IDX_W'(1);
            data_nx  = work_bytes[idx_nx];
            first_nx = 1'b0;
            last_nx  = (idx_nx == IDX_W'(F - 1));
          end else begin
            state_nx = SEND;
          end
        end
        default: begin
          state_nx = IDLE;
          valid_nx = 1'b0;
          first_nx = 1'b0;
          last_nx  = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= {IDX_W{1'b0}};
      cur_data  <= 8'h00;
      cur_valid <= 1'b0;
      cur_first <= 1'b0;
      cur_last  <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      cur_data  <= data_nx;
      cur_valid <= valid_nx;
      cur_first <= first_nx;
      cur_last  <= last_nx;
    end
  end

  // Working register holding the set currently being sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work <= {SET_W{1'b0}};
    end else if (load) begin
      work <= fifo_rdata;
    end else begin
      work <= work;
    end
  end

`ifdef IQ_SER_SYNC_HEADER_EN
  // Per-frame sequence counter carried in the header.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq <= 8'h00;
    end else begin
      seq <= seq_nx;
    end
  end
`endif

  // Sticky overflow: a capture that found the FIFO full with nothing leaving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (start) begin
      ovf <= 1'b0;
    end else if (capture && fifo_full && !pop) begin
      ovf <= 1'b1;
    end else begin
      ovf <= ovf;
    end
  end

endmodule
